dcache_port_arbiter: RTL and testbench

Shares the single data-cache port between two requesters: load reads from the load/store buffer, and committed stores from the reorder buffer's store-commit path. It latches the winning request, holds it stable to the cache until mem_resp, and routes the response back to the owner. Contended grants favour stores so commit can make progress, with a bounded starvation limit for loads. A flush cancels load traffic without aborting a cache transaction already in flight.

---
 rtl/dcache_port_arbiter_pkg.sv | 28 ++
 rtl/dcache_port_arbiter_req_latch.sv | 32 +++
 rtl/dcache_port_arbiter.sv | 123 ++++++++++++
 tb/tb_dcache_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// ============================================================================
// Module   : ooo_types (package)
// Brief    : Shared types for the data-cache port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ooo_types;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_STORE = 2'd2
    } arb_state_e;

    localparam int unsigned LD_STARVE_MAX_DEFAULT = 2;
    localparam int unsigned C_STARVE_W            = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byte_enable;
        logic        write;
    } dcache_req_t;

endpackage

`default_nettype wire

// File: rtl/dcache_port_arbiter_req_latch.sv
// ============================================================================
// Module   : dcache_req_latch
// Brief    : Holding register for the granted cache request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_req_latch
    import ooo_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  dcache_req_t i_d,
    output dcache_req_t o_q
);

    dcache_req_t r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
// ============================================================================
// Module   : dcache_port_arbiter
// Brief    : Shares the data-cache port between loads and committed stores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_port_arbiter
    import ooo_types::*;
#(
    parameter int unsigned LD_STARVE_MAX = LD_STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ld_read,
    input  logic [31:0] ld_address,
    output logic [31:0] ld_rdata,
    output logic        ld_resp,
    input  logic        st_write,
    input  logic [31:0] st_address,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_byte_enable,
    output logic        st_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_e            r_state;
    logic [C_STARVE_W-1:0] r_starve;
    logic                  r_drop;

    logic        w_idle;
    logic        w_ld_elig;
    logic        w_st_elig;
    logic        w_grant_st;
    logic        w_grant_ld;
    logic        w_ld_resp;
    dcache_req_t w_req_d;
    dcache_req_t w_req_q;

    assign w_idle    = (r_state == ARB_IDLE);
    assign w_ld_elig = ld_read && !flush;
    assign w_st_elig = st_write;

    // Stores win contention until the load has been passed over LD_STARVE_MAX times.
    assign w_grant_st = w_idle && w_st_elig &&
                        (!w_ld_elig || (r_starve < C_STARVE_W'(LD_STARVE_MAX)));
    assign w_grant_ld = w_idle && w_ld_elig && !w_grant_st;

    always_comb begin
        w_req_d.write       = w_grant_st;
        w_req_d.addr        = w_grant_st ? st_address : ld_address;
        w_req_d.wdata       = w_grant_st ? st_wdata : 32'h0;
        w_req_d.byte_enable = w_grant_st ? st_byte_enable : 4'hF;
    end

    dcache_req_latch u_req_latch (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_grant_st || w_grant_ld),
        .i_d  (w_req_d),
        .o_q  (w_req_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_starve <= '0;
            r_drop   <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_st) begin
                        r_state <= ARB_STORE;
                        if (w_ld_elig) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end else if (w_grant_ld) begin
                        r_state  <= ARB_LOAD;
                        r_starve <= '0;
                    end
                end
                ARB_LOAD: begin
                    // A flushed read still runs to completion; only its response is hidden.
                    if (mem_resp) begin
                        r_state <= ARB_IDLE;
                        r_drop  <= 1'b0;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                ARB_STORE: begin
                    if (mem_resp) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_read        = !w_idle && !w_req_q.write;
    assign mem_write       = !w_idle && w_req_q.write;
    assign mem_address     = w_req_q.addr;
    assign mem_wdata       = w_req_q.wdata;
    assign mem_byte_enable = mem_write ? w_req_q.byte_enable : 4'hF;

    assign w_ld_resp = (r_state == ARB_LOAD) && mem_resp && !r_drop && !flush;
    assign ld_resp   = w_ld_resp;
    assign ld_rdata  = w_ld_resp ? mem_rdata : 32'h0;
    assign st_resp   = (r_state == ARB_STORE) && mem_resp;

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
// ============================================================================
// Module   : tb_dcache_port_arbiter
// Brief    : Directed and random checks of the cache port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_port_arbiter;

    localparam int unsigned LD_MAX = 2;

    logic        clk = 1'b0;
    logic        rst, flush, ld_read, st_write, mem_resp;
    logic [31:0] ld_address, st_address, st_wdata, mem_rdata;
    logic [3:0]  st_byte_enable;
    logic [31:0] ld_rdata, mem_address, mem_wdata;
    logic        ld_resp, st_resp, mem_read, mem_write;
    logic [3:0]  mem_byte_enable;

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level reference: who owns the port (0 none, 1 load, 2 store).
    int          m_own    = 0;
    int          m_starve = 0;
    bit          m_drop   = 0;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    int n_ldresp = 0, n_stresp = 0, n_rd = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.LD_STARVE_MAX(LD_MAX)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_read(ld_read), .ld_address(ld_address), .ld_rdata(ld_rdata), .ld_resp(ld_resp),
        .st_write(st_write), .st_address(st_address), .st_wdata(st_wdata),
        .st_byte_enable(st_byte_enable), .st_resp(st_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_starve = 0; m_drop = 0;
        m_addr = '0; m_wdata = '0; m_be = '0;
    endtask

    // One clock: check outputs against the reference, then advance the reference.
    task automatic tick();
        bit e_ld, le, se;
        @(negedge clk);
        e_ld = (m_own == 1) && mem_resp && !m_drop && !flush;
        chk("mem_read",  32'(mem_read),  32'(m_own == 1));
        chk("mem_write", 32'(mem_write), 32'(m_own == 2));
        chk("ld_resp",   32'(ld_resp),   32'(e_ld));
        chk("ld_rdata",  ld_rdata,       e_ld ? mem_rdata : 32'h0);
        chk("st_resp",   32'(st_resp),   32'((m_own == 2) && mem_resp));
        if (m_own != 0) chk("mem_address", mem_address, m_addr);
        if (m_own == 2) begin
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_be",    32'(mem_byte_enable), 32'(m_be));
        end else begin
            chk("mem_be",    32'(mem_byte_enable), 32'hF);
        end
        n_ldresp += int'(ld_resp);
        n_stresp += int'(st_resp);
        n_rd     += int'(mem_read);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_own == 0) begin
            le = ld_read && !flush;
            se = st_write;
            if (se && (!le || m_starve < int'(LD_MAX))) begin
                m_own = 2;
                if (le) m_starve++;
                m_addr = st_address; m_wdata = st_wdata; m_be = st_byte_enable;
            end else if (le) begin
                m_own = 1; m_starve = 0; m_addr = ld_address;
            end
        end else if (mem_resp) begin
            m_own = 0; m_drop = 0;
        end else if (m_own == 1 && flush) begin
            m_drop = 1;
        end
        #1;
    endtask

    initial begin
        int          base_ld, base_st, base_rd;
        logic [1:0]  exp_ord [6];
        logic [1:0]  obs;
        exp_ord = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1};

        rst = 1; flush = 0; ld_read = 0; st_write = 0; mem_resp = 0;
        ld_address = 0; st_address = 0; st_wdata = 0; st_byte_enable = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;

        // Reset state
        chk("rst_mem_read",  32'(mem_read), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_addr",  mem_address, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be",    32'(mem_byte_enable), 32'hF);
        chk("rst_ld_rdata",  ld_rdata, 32'h0);
        tick();

        // Lone load, response three cycles after the strobe
        base_ld = n_ldresp;
        ld_read = 1; ld_address = 32'h1004;
        tick();
        tick(); tick();
        mem_resp = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        ld_read = 0; mem_resp = 0;
        tick();
        chk("lone_ld_pulses", 32'(n_ldresp - base_ld), 32'd1);

        // Lone store
        base_st = n_stresp; base_rd = n_rd;
        st_write = 1; st_address = 32'h2000; st_wdata = 32'hAB; st_byte_enable = 4'b0001;
        tick();
        tick(); tick();
        mem_resp = 1;
        tick();
        st_write = 0; mem_resp = 0;
        tick();
        chk("lone_st_pulses", 32'(n_stresp - base_st), 32'd1);
        chk("lone_st_no_rd",  32'(n_rd - base_rd), 32'd0);

        // Flush during a load
        base_ld = n_ldresp;
        ld_read = 1; ld_address = 32'h3000;
        tick();
        tick();
        flush = 1; ld_read = 0;
        tick();
        flush = 0; mem_resp = 1; mem_rdata = 32'h12345678;
        tick();
        mem_resp = 0;
        chk("flush_ld_no_resp", 32'(n_ldresp - base_ld), 32'd0);
        ld_read = 1; ld_address = 32'h3004;
        tick();
        mem_resp = 1;
        tick();
        ld_read = 0; mem_resp = 0;
        tick();
        chk("post_flush_ld", 32'(n_ldresp - base_ld), 32'd1);

        // Flush in IDLE with both requesting: store wins
        flush = 1; ld_read = 1; st_write = 1; st_address = 32'h4000;
        tick();
        flush = 0; ld_read = 0; st_write = 0;
        chk("flush_idle_st", 32'({mem_read, mem_write}), 32'b01);
        mem_resp = 1;
        tick();
        mem_resp = 0;
        flush = 1; ld_read = 1;
        tick();
        flush = 0; ld_read = 0;
        chk("flush_idle_ld", 32'(mem_read), 32'h0);
        tick();

        // Reset in the middle of a store
        base_st = n_stresp;
        st_write = 1; st_address = 32'h5000; st_wdata = 32'h55; st_byte_enable = 4'hC;
        tick();
        tick();
        rst = 1; st_write = 0;
        tick();
        rst = 0; mem_resp = 1;
        chk("rst_mid_write", 32'(mem_write), 32'h0);
        tick();
        mem_resp = 0;
        chk("rst_mid_no_resp", 32'(n_stresp - base_st), 32'd0);

        // Contention: starvation limit gives S,S,L,S,S,L
        ld_read = 1; st_write = 1; ld_address = 32'h6000; st_address = 32'h7000;
        for (int i = 0; i < 6; i++) begin
            mem_resp = 0;
            tick();
            obs = {mem_write, mem_read} == 2'b10 ? 2'd2 : ({mem_write, mem_read} == 2'b01 ? 2'd1 : 2'd0);
            chk($sformatf("grant_order_%0d", i), 32'(obs), 32'(exp_ord[i]));
            mem_resp = 1;
            tick();
        end
        ld_read = 0; st_write = 0; mem_resp = 0;
        tick();

        // Random traffic against the reference
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(99) == 0);
            flush          = ($urandom_range(5) == 0);
            ld_read        = 1'($urandom_range(1));
            st_write       = 1'($urandom_range(1));
            mem_resp       = ($urandom_range(2) == 0);
            ld_address     = $urandom;
            st_address     = $urandom;
            st_wdata       = $urandom;
            st_byte_enable = 4'($urandom);
            mem_rdata      = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
